// File: rtl/stopwatch_controller.sv
// stopwatch_controller: hundredth-second stopwatch timebase and start/pause/lap/clear sequencer.
// Holds BCD mm:ss.hh time and presents registered display digits to the terminal text formatter.
// Ports:
//   clk, reset_n         : single clock, synchronous active-low reset
//   start_stop/clear/lap : one-cycle command pulses (priority clear > start_stop > lap)
//   hund_*/sec_*/min_*   : registered BCD display digits
//   running, lap_hold    : state flags (RUNNING or LAP / LAP only)
//   tick, overflow       : one-cycle pulses aligned with the display update
//   state                : IDLE=0, RUNNING=1, PAUSED=2, LAP=3
module stopwatch_controller #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TICK_HZ     = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] hund_ones,
  output logic [3:0] hund_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_hold,
  output logic       tick,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] hund_tens;
    logic [3:0] hund_ones;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = bcd_time_t'(24'h595999);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  bcd_time_t     cnt_q, cnt_d;
  bcd_time_t     disp_q, disp_d;
  logic          inc_q, inc_d;
  logic          wrap_q, wrap_d;
  logic          tick_q, tick_d;
  logic          ovf_q, ovf_d;
  logic          running_q, running_d;
  logic          lap_hold_q, lap_hold_d;

  logic counting;
  logic tick_en;
  logic cmd_ss;
  logic cmd_lap;

  // Single BCD digit increment with limit; returns {carry_out, digit}.
  function automatic logic [4:0] dig_inc(input logic [3:0] d, input logic [3:0] lim,
                                         input logic cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (d == lim) r = {1'b1, 4'd0};
      else          r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

  // Ripple-carry BCD increment of mm:ss.hh; 59:59.99 wraps to zero.
  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t r;
    logic      c;
    {c, r.hund_ones} = dig_inc(t.hund_ones, 4'd9, 1'b1);
    {c, r.hund_tens} = dig_inc(t.hund_tens, 4'd9, c);
    {c, r.sec_ones}  = dig_inc(t.sec_ones,  4'd9, c);
    {c, r.sec_tens}  = dig_inc(t.sec_tens,  4'd5, c);
    {c, r.min_ones}  = dig_inc(t.min_ones,  4'd9, c);
    {c, r.min_tens}  = dig_inc(t.min_tens,  4'd5, c);
    return r;
  endfunction

  assign counting = (state_q == RUNNING) || (state_q == LAP);
  assign tick_en  = counting && (pre_q == PRE_MAX);
  assign cmd_ss   = start_stop && !clear;
  assign cmd_lap  = lap && !clear && !start_stop;

  // Next-state, timebase, counters and display.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    inc_d   = 1'b0;
    wrap_d  = 1'b0;
    tick_d  = 1'b0;
    ovf_d   = 1'b0;

    unique case (state_q)
      IDLE:    if (cmd_ss) state_d = RUNNING;
      RUNNING: if (cmd_ss) state_d = PAUSED;
               else if (cmd_lap) state_d = LAP;
      PAUSED:  if (cmd_ss) state_d = RUNNING;
      LAP:     if (cmd_ss) state_d = PAUSED;
               else if (cmd_lap) state_d = RUNNING;
      default: state_d = IDLE;
    endcase

    // Prescaler holds in PAUSED so a resume continues the partial period.
    if (state_q == IDLE)  pre_d = '0;
    else if (counting)    pre_d = tick_en ? '0 : pre_q + PW'(1);

    if (tick_en) begin
      cnt_d  = time_inc(cnt_q);
      inc_d  = 1'b1;
      wrap_d = (cnt_q == TIME_MAX);
    end

    // Display tracks counters one cycle behind except while frozen in LAP.
    if (state_q != LAP) disp_d = cnt_q;
    tick_d = inc_q && (state_q != LAP);
    ovf_d  = wrap_q;

    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      cnt_d   = '0;
      disp_d  = '0;
      inc_d   = 1'b0;
      wrap_d  = 1'b0;
      tick_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    running_d  = (state_d == RUNNING) || (state_d == LAP);
    lap_hold_d = (state_d == LAP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      inc_q      <= 1'b0;
      wrap_q     <= 1'b0;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      inc_q      <= inc_d;
      wrap_q     <= wrap_d;
      tick_q     <= tick_d;
      ovf_q      <= ovf_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign hund_ones = disp_q.hund_ones;
  assign hund_tens = disp_q.hund_tens;
  assign sec_ones  = disp_q.sec_ones;
  assign sec_tens  = disp_q.sec_tens;
  assign min_ones  = disp_q.min_ones;
  assign min_tens  = disp_q.min_tens;
  assign running   = running_q;
  assign lap_hold  = lap_hold_q;
  assign tick      = tick_q;
  assign overflow  = ovf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: directed bench for stopwatch_controller with DIV=10.
module tb_stopwatch_controller;

  logic       clk = 1'b0;
  logic       reset_n, start_stop, clear, lap;
  logic [3:0] hund_ones, hund_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_hold, tick, overflow;
  logic [1:0] state;
  logic [31:0] disp;
  logic [23:0] force_val;

  stopwatch_controller #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .hund_ones  (hund_ones),
    .hund_tens  (hund_tens),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .lap_hold   (lap_hold),
    .tick       (tick),
    .overflow   (overflow),
    .state      (state)
  );

  assign disp = {8'h00, min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones};

  always #5 clk = ~clk;

  int cyc = 0;
  int tick_cnt = 0;
  int ov_cnt = 0;
  int gap_bad = 0;
  int last_tick = 0;
  bit gap_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts ticks/overflows and flags tick spacing other than 10 cycles.
  always @(negedge clk) begin
    if (tick) begin
      tick_cnt++;
      if (gap_en && last_tick != 0 && (cyc - last_tick) != 10) gap_bad++;
      last_tick = cyc;
    end
    if (overflow) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n cycles; main-thread activity happens just after each falling edge.
  task automatic nxt(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Present commands for exactly one rising edge.
  task automatic pulse(input logic ss, input logic cl, input logic lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    nxt(1);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_disp"}, disp, 32'h0);
    chk({nm, "_state"}, 32'(state), 32'd0);
    chk({nm, "_running"}, 32'(running), 32'd0);
    chk({nm, "_lap_hold"}, 32'(lap_hold), 32'd0);
    chk({nm, "_tick"}, 32'(tick), 32'd0);
    chk({nm, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Start, pause with prescaler at 1, force counters to v, resume and watch two increments.
  task run_force(input string nm, input logic [23:0] v, input logic [23:0] n1,
                 input logic [23:0] n2, input logic ov2);
    pulse(1'b0, 1'b1, 1'b0);
    start_stop = 1'b1;
    nxt(2);
    start_stop = 1'b0;
    chk({nm, "_paused"}, 32'(state), 32'd2);
    force_val = v;
    force dut.cnt_q = force_val;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    nxt(1);
    chk({nm, "_load"}, disp, {8'h00, v});
    ov_cnt = 0;
    pulse(1'b1, 1'b0, 1'b0);
    nxt(10);
    chk({nm, "_tick1"}, 32'(tick), 32'd1);
    chk({nm, "_n1"}, disp, {8'h00, n1});
    chk({nm, "_ovf1"}, 32'(overflow), 32'd0);
    nxt(10);
    chk({nm, "_tick2"}, 32'(tick), 32'd1);
    chk({nm, "_n2"}, disp, {8'h00, n2});
    chk({nm, "_ovf2"}, 32'(overflow), 32'(ov2));
    nxt(1);
    chk({nm, "_ovf_cnt"}, 32'(ov_cnt), 32'(ov2));
  endtask

  initial begin
    reset_n    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    force_val  = '0;

    // Reset then idle
    nxt(3);
    chk_zero("rst");
    reset_n  = 1'b1;
    tick_cnt = 0;
    nxt(50);
    chk_zero("idle");
    chk("idle_ticks", 32'(tick_cnt), 32'd0);

    // Start and count
    last_tick = 0;
    gap_en    = 1'b1;
    tick_cnt  = 0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_state", 32'(state), 32'd1);
    nxt(251);
    chk("run_ticks", 32'(tick_cnt), 32'd25);
    chk("run_disp", disp, 32'h000025);
    chk("run_gap", 32'(gap_bad), 32'd0);
    chk("run_running", 32'(running), 32'd1);
    gap_en = 1'b0;

    // Pause/resume accuracy
    pulse(1'b0, 1'b1, 1'b0);
    chk_zero("clr1");
    pulse(1'b1, 1'b0, 1'b0);
    nxt(34);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_disp", disp, 32'h000003);
    chk("pause_running", 32'(running), 32'd0);
    tick_cnt = 0;
    nxt(100);
    chk("pause_hold", disp, 32'h000003);
    chk("pause_ticks", 32'(tick_cnt), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    nxt(5);
    chk("resume_early", 32'(tick), 32'd0);
    chk("resume_early_disp", disp, 32'h000003);
    nxt(1);
    chk("resume_tick", 32'(tick), 32'd1);
    chk("resume_disp", disp, 32'h000004);

    // Lap freeze
    nxt(83);
    pulse(1'b0, 1'b0, 1'b1);
    chk("lap_state", 32'(state), 32'd3);
    chk("lap_hold", 32'(lap_hold), 32'd1);
    chk("lap_running", 32'(running), 32'd1);
    chk("lap_capture", disp, 32'h000012);
    tick_cnt = 0;
    nxt(80);
    chk("lap_frozen", disp, 32'h000012);
    chk("lap_no_tick", 32'(tick_cnt), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("unlap_state", 32'(state), 32'd1);
    chk("unlap_hold", 32'(lap_hold), 32'd0);
    chk("unlap_disp0", disp, 32'h000012);
    nxt(1);
    chk("unlap_resync", disp, 32'h000020);

    // Simultaneous commands
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    nxt(1505);
    chk("sim_pre_disp", disp, 32'h000150);
    chk("sim_pre_state", 32'(state), 32'd1);
    pulse(1'b1, 1'b1, 1'b1);
    chk_zero("sim_clr");
    pulse(1'b1, 1'b0, 1'b1);
    chk("sim_start_state", 32'(state), 32'd1);
    chk("sim_start_lap_hold", 32'(lap_hold), 32'd0);
    chk("sim_start_running", 32'(running), 32'd1);

    // Clear landing on the increment edge
    nxt(9);
    pulse(1'b0, 1'b1, 1'b0);
    chk_zero("clr_on_tick");
    nxt(1);
    chk("clr_on_tick_after", 32'(tick), 32'd0);
    chk("clr_on_tick_disp", disp, 32'h0);

    // Carry and wrap
    run_force("wrap", 24'h595998, 24'h595999, 24'h000000, 1'b1);
    run_force("min_carry", 24'h095998, 24'h095999, 24'h100000, 1'b0);
    run_force("sec_carry", 24'h005998, 24'h005999, 24'h010000, 1'b0);

    // Reset mid-count discards time
    nxt(5);
    reset_n = 1'b0;
    nxt(1);
    reset_n = 1'b1;
    chk_zero("mid_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Sequences the hundredth-second timebase for the pseudo-terminal stopwatch/clock display. It derives a single-cycle 1/100 s enable from `clk` and never generates a derived clock. It runs a start/pause/lap/clear state machine and maintains BCD mm:ss.hh time. It presents registered digits to the display/terminal text formatter.

Parameters:
CLK_FREQ_HZ, 100000000, frequency of `clk` in Hz
TICK_HZ, 100, timebase rate. DIV = CLK_FREQ_HZ/TICK_HZ, which must be an integer ≥ 2. Prescaler width is clog2(DIV).

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  synchronous reset, active-low, sampled on rising edge of `clk`
start_stop  input  1  one-cycle command pulse: start, pause or resume
clear  input  1  one-cycle command pulse: return to IDLE and zero time
lap  input  1  one-cycle command pulse: freeze or unfreeze displayed time
hund_ones, hund_tens, sec_ones, sec_tens, min_ones, min_tens  output  4 each  registered BCD display digits
running  output  1  high in RUNNING or LAP
lap_hold  output  1  high in LAP (display frozen)
tick  output  1  one-cycle pulse, coincident with each display update caused by a time increment
overflow  output  1  one-cycle pulse when time wraps 59:59.99 -> 00:00.00
state  output  2  IDLE=0, RUNNING=1, PAUSED=2, LAP=3

Behaviour:
- Reset (`reset_n`=0 at an edge): state=IDLE, prescaler=0, all time counters=0, all digit outputs=0, running=0, lap_hold=0, tick=0, overflow=0.
  - Reset mid-count discards all time immediately.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING or LAP.
  - Holds its value in PAUSED, so a resume continues the partial period.
  - Forced to 0 in IDLE.
- Internal `tick_en` = counting state AND prescaler==DIV-1.
  - On that edge the prescaler returns to 0 and the time counters increment.
- Time counters:
  - hundredths 00-99, carries to seconds 00-59, carries to minutes 00-59.
  - Each field uses BCD digit arithmetic; no binary-to-BCD conversion.
  - Wrap at 59:59.99 -> 00:00.00: counting continues and `overflow` pulses.
- Display registers:
  - Load from the time counters one cycle after each increment, except in LAP.
  - `tick` and `overflow` are registered and align with that display update, so latency is 1 cycle from the counter edge.
  - In LAP the display registers hold the value captured on LAP entry; counters keep running.
  - `tick` pulses only when the display actually updates, so it is suppressed in LAP.
  - `overflow` still pulses in LAP.
- Command priority within one cycle: clear > start_stop > lap. Lower-priority commands in the same cycle are dropped.
- Transitions:
  - IDLE: start_stop -> RUNNING. lap ignored.
  - RUNNING: start_stop -> PAUSED. lap -> LAP (captures current counter value to display).
  - PAUSED: start_stop -> RUNNING. lap ignored.
  - LAP: lap -> RUNNING, and the display resyncs to live time on the next cycle. start_stop -> PAUSED, and the display resyncs to the live stopped time next cycle.
  - Any state: clear -> IDLE. Counters, prescaler and display are zeroed on the next edge.
- Command landing in the same cycle as `tick_en`:
  - Pause: the increment still takes effect and the prescaler restarts at 0 when resumed.
  - Clear: wins, and the result is all zero.
- Commands are level-sampled. Upstream debounce/one-pulse supplies single-cycle pulses, so holding a command high re-triggers every cycle.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset then idle: hold `reset_n`=0 for 3 cycles, release, wait 50 cycles -> all digits 0, state=0, no `tick` pulses.
- Start and count: pulse `start_stop`, run 250 cycles -> `tick` every 10 cycles exactly. Display reads 00:00.25 and running=1.
- Pause/resume accuracy: start, pause at prescaler=4 after 3 ticks, idle 100 cycles, resume -> next `tick` arrives 6 cycles after resume. Display goes 00:00.03 -> 00:00.04.
- Lap freeze: lap at 00:00.12, wait 80 cycles -> display stays 00:00.12 with no `tick`. Second lap -> display shows 00:00.20 one cycle later.
- Carry and wrap: force counters via a run of 360000 ticks -> display 59:59.99 then 00:00.00. `overflow` pulses once, aligned with that update.
- Simultaneous commands and clear: clear+start_stop+lap in one cycle while RUNNING at 00:01.50 -> state=IDLE, all zero next cycle. Then start_stop+lap in IDLE -> RUNNING only, lap_hold=0.
